// File: rtl/mem_responder_if.sv
// CPU-side memory bus: command, address and write data in; read data, valid and busy out.
interface mem_responder_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;

    modport master (output mem_cmd, mem_addr, din, input dout, dout_valid, busy);
    modport slave  (input mem_cmd, mem_addr, din, output dout, dout_valid, busy);
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM with configurable read latency, LED/switch I/O
// registers, and a sticky error flag for illegal commands or unmapped addresses.
module mem_responder #(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 256,
    parameter int                READ_LAT = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    input  logic [7:0]      sw,
    output logic [7:0]      led,
    output logic            err
);
    localparam int          RAM_AW   = $clog2(DEPTH);
    localparam logic [1:0]  MNONE    = 2'b00;
    localparam logic [1:0]  MREAD    = 2'b01;
    localparam logic [1:0]  MWRITE   = 2'b10;
    localparam logic [1:0]  CNT_INIT = (READ_LAT >= 2) ? 2'(READ_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e            state_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic [7:0]        led_q;
    logic              err_q;

    logic [DATA_W-1:0] ram [DEPTH];

    logic              accept;
    logic              we;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_bad;

    function automatic logic in_ram(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    assign accept = (state_q != WAIT) && (bus.mem_cmd != MNONE);
    assign we     = accept && (bus.mem_cmd == MWRITE) && in_ram(bus.mem_addr);

    // Single-cycle reads use the live address; longer latencies use the captured one.
    assign rd_addr = (state_q == WAIT) ? addr_q : bus.mem_addr;

    always_comb begin
        rd_data = '0;
        rd_bad  = 1'b0;
        if (in_ram(rd_addr))
            rd_data = ram[rd_addr[RAM_AW-1:0]];
        else if (rd_addr == SW_ADDR)
            rd_data = DATA_W'(sw);
        else
            rd_bad = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (we)
            ram[bus.mem_addr[RAM_AW-1:0]] <= bus.din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            led_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        state_q <= RESP;
                        dout_q  <= rd_data;
                        err_q   <= err_q | rd_bad;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    if (accept) begin
                        case (bus.mem_cmd)
                            MREAD: begin
                                addr_q <= bus.mem_addr;
                                if (READ_LAT == 1) begin
                                    state_q <= RESP;
                                    dout_q  <= rd_data;
                                    err_q   <= err_q | rd_bad;
                                end else begin
                                    state_q <= WAIT;
                                    cnt_q   <= CNT_INIT;
                                end
                            end
                            MWRITE: begin
                                if (bus.mem_addr == LED_ADDR)
                                    led_q <= bus.din[7:0];
                                else if (!in_ram(bus.mem_addr))
                                    err_q <= 1'b1;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = (state_q == RESP);
    assign bus.busy       = (state_q == WAIT);
    assign led            = led_q;
    assign err            = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Four responders with READ_LAT 1..4 driven by directed steps; a cycle model predicts
// acceptance, busy, err and led, and a per-instance queue holds expected read responses.
module tb_mem_responder;
    typedef struct {
        int          due;
        logic [15:0] data;
        bit          bad;
    } exp_t;

    logic        clk;
    logic [7:0]  sw;
    logic        rst_n [4];
    logic [1:0]  cmd   [4];
    logic [8:0]  addr  [4];
    logic [15:0] din   [4];
    logic [15:0] dout  [4];
    logic        dv    [4];
    logic        busy  [4];
    logic [7:0]  led   [4];
    logic        err   [4];

    exp_t        sbq   [4][$];
    int          bu    [4];
    logic        err_m [4];
    logic [7:0]  led_m [4];
    logic [15:0] dout_m[4];
    logic [15:0] mem_m [4][512];
    int          ecnt;
    int          total;
    int          passed;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_responder_if #(.ADDR_W(9), .DATA_W(16)) bus ();
        assign bus.mem_cmd  = cmd[g];
        assign bus.mem_addr = addr[g];
        assign bus.din      = din[g];
        assign dout[g]      = bus.dout;
        assign dv[g]        = bus.dout_valid;
        assign busy[g]      = bus.busy;
        mem_responder #(.READ_LAT(g + 1)) dut (
            .clk (clk),
            .rst (rst_n[g]),
            .bus (bus),
            .sw  (sw),
            .led (led[g]),
            .err (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_accept(input int k);
        int   lat;
        exp_t e;
        lat = k + 1;
        case (cmd[k])
            2'b01: begin
                e.due  = ecnt + lat - 1;
                e.bad  = 1'b0;
                if (addr[k] < 9'd256)       e.data = mem_m[k][addr[k]];
                else if (addr[k] == 9'h140) e.data = {8'h00, sw};
                else begin e.data = 16'h0; e.bad = 1'b1; end
                sbq[k].push_back(e);
                bu[k] = ecnt + lat - 2;
            end
            2'b10: begin
                if (addr[k] < 9'd256)       mem_m[k][addr[k]] = din[k];
                else if (addr[k] == 9'h100) led_m[k] = din[k][7:0];
                else                        err_m[k] = 1'b1;
            end
            default: err_m[k] = 1'b1;
        endcase
    endtask

    task automatic check(input int k);
        logic exp_dv;
        exp_dv = (sbq[k].size() > 0) && (sbq[k][0].due == ecnt);
        if (exp_dv) begin
            dout_m[k] = sbq[k][0].data;
            void'(sbq[k].pop_front());
        end
        chk($sformatf("dv[%0d]@%0d", k, ecnt), dv[k], exp_dv);
        chk($sformatf("dout[%0d]@%0d", k, ecnt), dout[k], dout_m[k]);
        chk($sformatf("busy[%0d]@%0d", k, ecnt), busy[k], rst_n[k] && (ecnt <= bu[k]));
        chk($sformatf("led[%0d]@%0d", k, ecnt), led[k], led_m[k]);
        chk($sformatf("err[%0d]@%0d", k, ecnt), err[k], err_m[k]);
    endtask

    task automatic cyc();
        @(posedge clk);
        ecnt++;
        for (int k = 0; k < 4; k++) begin
            if (rst_n[k]) begin
                if (cmd[k] != 2'b00 && !(ecnt - 1 <= bu[k])) model_accept(k);
                if (sbq[k].size() > 0 && sbq[k][0].due == ecnt && sbq[k][0].bad) err_m[k] = 1'b1;
            end
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) check(k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic issue(input int k, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        cmd[k]  = c;
        addr[k] = a;
        din[k]  = d;
        cyc();
        cmd[k]  = 2'b00;
    endtask

    task automatic clear_model(input int k);
        sbq[k].delete();
        bu[k]     = -1;
        err_m[k]  = 1'b0;
        led_m[k]  = 8'h00;
        dout_m[k] = 16'h0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        ecnt   = 0;
        sw     = 8'h3C;
        for (int k = 0; k < 4; k++) begin
            rst_n[k] = 1'b0;
            cmd[k]   = 2'b00;
            addr[k]  = '0;
            din[k]   = '0;
            clear_model(k);
        end

        // reset state
        idle(2);
        for (int k = 0; k < 4; k++) rst_n[k] = 1'b1;
        idle(1);

        // READ_LAT=1: write then read, no busy
        issue(0, 2'b10, 9'h005, 16'hBEEF);
        issue(0, 2'b01, 9'h005, 16'h0);
        idle(2);

        // READ_LAT=3: busy two cycles, write during busy dropped
        issue(2, 2'b10, 9'h005, 16'hBEEF);
        issue(2, 2'b01, 9'h005, 16'h0);
        issue(2, 2'b10, 9'h005, 16'h1234);
        idle(3);
        issue(2, 2'b01, 9'h005, 16'h0);
        idle(4);

        // READ_LAT=2: back-to-back reads, second issued in the RESP cycle
        issue(1, 2'b10, 9'h001, 16'h1111);
        issue(1, 2'b10, 9'h002, 16'h2222);
        issue(1, 2'b01, 9'h001, 16'h0);
        idle(1);
        issue(1, 2'b01, 9'h002, 16'h0);
        idle(3);

        // I/O registers and unmapped read
        issue(1, 2'b10, 9'h100, 16'h00A5);
        issue(1, 2'b01, 9'h140, 16'h0);
        idle(2);
        issue(1, 2'b01, 9'h101, 16'h0);
        idle(4);

        // illegal command and unmapped write leave RAM and led alone
        issue(0, 2'b11, 9'h005, 16'h9999);
        idle(1);
        issue(0, 2'b10, 9'h1FF, 16'h7777);
        issue(0, 2'b01, 9'h005, 16'h0);
        idle(2);

        // READ_LAT=4: async reset during WAIT aborts the read
        issue(3, 2'b10, 9'h100, 16'h005A);
        issue(3, 2'b10, 9'h007, 16'hCAFE);
        issue(3, 2'b01, 9'h007, 16'h0);
        idle(1);
        #2;
        rst_n[3] = 1'b0;
        clear_model(3);
        #1;
        check(3);
        idle(3);
        rst_n[3] = 1'b1;
        idle(5);
        issue(3, 2'b01, 9'h007, 16'h0);
        idle(5);

        for (int k = 0; k < 4; k++)
            chk($sformatf("pending[%0d]", k), sbq[k].size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
